muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Iterative multi-cycle RV32M execute unit that sits beside the single-cycle ALU in the EX stage. It implements all eight M-extension operations at parametrised width XLEN. Multiplies use radix-2 shift-add and divides use radix-2 restoring division. A valid/ready handshake on the input and a hold-until-ack output let the pipeline stall EX while the unit is busy.

Parameters:
XLEN, 32, operand and result width (≥ 8, even)
CNT_W, $clog2(XLEN+1), iteration counter width (derived, not overridden)

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  synchronous, active-high reset
i_valid  in  1  operation request
o_ready  out  1  unit idle, can accept a request this cycle
i_op_a  in  XLEN  rs1 operand (multiplicand / dividend)
i_op_b  in  XLEN  rs2 operand (multiplier / divisor)
i_md_op  in  3  funct3 op select (see package)
i_flush  in  1  kill in-flight operation (branch mispredict / trap)
o_valid  out  1  result available; held until acknowledged
i_ack  in  1  consumer takes result
o_result  out  XLEN  result word

Behaviour:
- States: IDLE, CALC, FIX, DONE. Reset → IDLE, o_valid=0, o_ready=1, o_result=0, counter=0.
- o_ready = (state==IDLE). Accept occurs on the edge where i_valid && o_ready. Op, signs, absolute-value magnitudes of the operands, and the negate-result flag are latched at that edge.
- Signedness: MUL/MULH/DIV/REM use signed a and b. MULHSU uses signed a and unsigned b. MULHU/DIVU/REMU use unsigned a and b.
- Fast path (division only):
  - b==0: quotient = all ones, remainder = a.
  - Signed overflow (a == 2^(XLEN-1), b == all ones): quotient = a, remainder = 0.
  - Both cases go IDLE → DONE directly, so o_valid is high 1 cycle after accept.
- Normal path: IDLE → CALC with counter=0. Each CALC cycle performs one shift-add or restoring-subtract step on the 2*XLEN accumulator; counter increments. When counter == XLEN-1, go to FIX.
- FIX (1 cycle): apply the two's-complement negate if flagged, then select the output.
  - MUL → low half of the product.
  - MULH* → high half of the product.
  - DIV* → quotient.
  - REM* → remainder.
  - Remainder sign follows the dividend. Quotient sign is sign(a) XOR sign(b).
  - FIX → DONE.
- Latency, normal path: o_valid is high XLEN+2 cycles after the accept edge (34 for XLEN=32).
- DONE: o_valid=1 and o_result stable until i_ack. On i_ack, → IDLE, and o_valid drops on the next cycle. A new accept is possible the cycle after that, because o_ready is never high in DONE, so accept and ack never coincide.
- i_flush in any non-IDLE state → IDLE next cycle. o_valid deasserts and no result is delivered. Flush beats ack. Flush in IDLE is a no-op and does not block an accept in that same cycle.
- i_reset mid-operation: same effect as flush, and every output returns to its reset value.
- Inputs are ignored while not in IDLE. Operands are not required to be held after accept.
- Arithmetic: all intermediate math is unsigned on XLEN+1 / 2*XLEN bits with wrap-around. No exceptions are raised.

Decomposition:
- Package muldiv_pkg holds:
  - md_op_e: MUL=3'b000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111.
  - md_state_e.
  - Helper function is_div(op) = op[2].
- One natural sub-module, muldiv_step: combinational single iteration (shift-add or restoring subtract) on the accumulator, parametrised by XLEN. The FSM and operand/sign handling stay in muldiv_unit.

Test Plan:
- MUL 7 × 0xFFFFFFFD (−3) → 0xFFFFFFEB. o_valid rises exactly 34 cycles after accept. o_ready is low throughout.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD. REM → 0xFFFFFFFF. DIVU 0xFFFFFFFE / 2 → 0x7FFFFFFF. REMU 10 / 3 → 1.
- Corner cases:
  - DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
  - All four give o_valid 1 cycle after accept.
- Back-pressure: hold i_ack low 5 cycles in DONE. o_result and o_valid stay stable and o_ready stays 0. Pulse i_ack: o_ready=1 on the next cycle and a back-to-back DIVU is accepted.
- Assert i_flush at CALC counter=10 → IDLE next cycle, o_valid never rises. Repeat with i_reset at counter=20 → all outputs return to reset values. A following MUL 3×4 → 12.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op encodings, FSM states and op-decode helpers for the RV32M unit
package muldiv_pkg;

    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } md_state_e;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic a_signed(input logic [2:0] op);
        return !(op == MULHU || op == DIVU || op == REMU);
    endfunction

    function automatic logic b_signed(input logic [2:0] op);
        return op == MUL || op == MULH || op == DIV || op == REM;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 shift-add (multiply) or restoring-subtract (divide) iteration
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   mag,
    input  logic              div,
    output logic [2*XLEN-1:0] acc_next
);

    logic [XLEN:0] sum;
    logic [XLEN:0] rem_sh;
    logic [XLEN:0] diff;

    // Multiply: {hi,lo} holds partial product / multiplier; divide: {rem,quo} shifted left each step
    always_comb begin
        sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag} : '0);
        rem_sh   = acc[2*XLEN-1:XLEN-1];
        diff     = rem_sh - {1'b0, mag};
        acc_next = div ? {(diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0]), acc[XLEN-2:0], ~diff[XLEN]}
                       : {sum, acc[XLEN-1:1]};
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit with valid/ready input and hold-until-ack output
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter  int XLEN  = 32,
    localparam int CNT_W = $clog2(XLEN + 1)
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [XLEN-1:0] i_op_a,
    input  logic [XLEN-1:0] i_op_b,
    input  logic [2:0]      i_md_op,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ack,
    output logic [XLEN-1:0] o_result
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e         state;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        op;
    logic              neg;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] acc_next;
    logic [XLEN-1:0]   mag;
    logic              sa;
    logic              sb;
    logic              neg_in;
    logic              div_zero;
    logic              div_ovf;
    logic [XLEN-1:0]   abs_a;
    logic [XLEN-1:0]   abs_b;
    logic [XLEN-1:0]   fast_result;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   fix_result;

    // Decode the incoming request: operand magnitudes, result sign and divide short-cuts
    always_comb begin
        sa          = a_signed(i_md_op) & i_op_a[XLEN-1];
        sb          = b_signed(i_md_op) & i_op_b[XLEN-1];
        abs_a       = sa ? -i_op_a : i_op_a;
        abs_b       = sb ? -i_op_b : i_op_b;
        neg_in      = (is_div(i_md_op) && i_md_op[1]) ? sa : sa ^ sb;
        div_zero    = is_div(i_md_op) && i_op_b == '0;
        div_ovf     = is_div(i_md_op) && !i_md_op[0] && i_op_a == MIN_NEG && i_op_b == '1;
        fast_result = i_md_op[1] ? (div_zero ? i_op_a : '0) : (div_zero ? '1 : i_op_a);
    end

    // Sign-correct the finished accumulator and pick the half the op asks for
    always_comb begin
        prod       = neg ? -acc : acc;
        quo        = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem        = neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        fix_result = is_div(op) ? (op[1] ? rem : quo) : (op == MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
    end

    muldiv_step #(.XLEN(XLEN)) u_step (
        .acc      (acc),
        .mag      (mag),
        .div      (is_div(op)),
        .acc_next (acc_next)
    );

    // Control FSM; o_valid lags entry into DONE by one cycle and ack is honoured only once it is visible
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= IDLE;
            cnt      <= '0;
            op       <= '0;
            neg      <= 1'b0;
            acc      <= '0;
            mag      <= '0;
            o_valid  <= 1'b0;
            o_ready  <= 1'b1;
            o_result <= '0;
        end else if (i_flush && state != IDLE) begin
            state   <= IDLE;
            cnt     <= '0;
            o_valid <= 1'b0;
            o_ready <= 1'b1;
        end else begin
            case (state)
                IDLE: if (i_valid) begin
                    op      <= i_md_op;
                    neg     <= neg_in;
                    cnt     <= '0;
                    o_ready <= 1'b0;
                    if (div_zero || div_ovf) begin
                        state    <= DONE;
                        o_result <= fast_result;
                    end else begin
                        state <= CALC;
                        acc   <= {{XLEN{1'b0}}, is_div(i_md_op) ? abs_a : abs_b};
                        mag   <= is_div(i_md_op) ? abs_b : abs_a;
                    end
                end
                CALC: begin
                    acc   <= acc_next;
                    cnt   <= cnt + 1'b1;
                    state <= cnt == CNT_W'(XLEN - 1) ? FIX : CALC;
                end
                FIX: begin
                    o_result <= fix_result;
                    state    <= DONE;
                end
                DONE: if (i_ack && o_valid) begin
                    state   <= IDLE;
                    o_valid <= 1'b0;
                    o_ready <= 1'b1;
                end else begin
                    o_valid <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid = 1'b0;
    logic        ready;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [2:0]  md_op = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        ack = 1'b0;
    logic [31:0] result;
    int          n_cmp = 0;
    int          n_bad = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_valid  (valid),
        .o_ready  (ready),
        .i_op_a   (op_a),
        .i_op_b   (op_b),
        .i_md_op  (md_op),
        .i_flush  (flush),
        .o_valid  (out_valid),
        .i_ack    (ack),
        .o_result (result)
    );

    always #5 clk = ~clk;

    task automatic start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        md_op = op;
        op_a  = a;
        op_b  = b;
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        op_a  = 32'hDEAD_BEEF;
        op_b  = 32'h1234_5678;
        md_op = 3'b000;
    endtask

    task automatic wait_valid(output int lat);
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic do_ack();
        ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_cmp++;
        if (ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", ready); end
        n_cmp++;
        if (result !== 32'h0) begin n_bad++; $display("FAIL reset_result got %h want 0", result); end
    endtask

    task automatic test_mul_latency();
        int lat;
        bit busy_bad;
        busy_bad = 0;
        lat = -1;
        start(3'b000, 32'd7, 32'hFFFF_FFFD);
        for (int i = 1; i <= 100; i++) begin
            if (ready !== 1'b0) busy_bad = 1;
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        n_cmp++;
        if (busy_bad) begin n_bad++; $display("FAIL mul_ready_busy got 1 want 0 while busy"); end
        n_cmp++;
        if (lat !== 34) begin n_bad++; $display("FAIL mul_latency got %0d want 34", lat); end
        n_cmp++;
        if (result !== 32'hFFFF_FFEB) begin n_bad++; $display("FAIL mul got %h want ffffffeb", result); end
        do_ack();
    endtask

    task automatic test_mul_high();
        logic [2:0]  ops [3] = '{3'b001, 3'b011, 3'b010};
        logic [31:0] as  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] bs  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exp [3] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        int lat;
        for (int k = 0; k < 3; k++) begin
            start(ops[k], as[k], bs[k]);
            wait_valid(lat);
            n_cmp++;
            if (lat !== 34 || result !== exp[k])
                begin n_bad++; $display("FAIL mulh_%0d got %h lat %0d want %h lat 34", k, result, lat, exp[k]); end
            do_ack();
        end
    endtask

    task automatic test_div();
        logic [2:0]  ops [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
        logic [31:0] as  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd10};
        logic [31:0] bs  [4] = '{32'd2, 32'd2, 32'd2, 32'd3};
        logic [31:0] exp [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd1};
        int lat;
        for (int k = 0; k < 4; k++) begin
            start(ops[k], as[k], bs[k]);
            wait_valid(lat);
            n_cmp++;
            if (lat !== 34 || result !== exp[k])
                begin n_bad++; $display("FAIL div_%0d got %h lat %0d want %h lat 34", k, result, lat, exp[k]); end
            do_ack();
        end
    endtask

    task automatic test_corners();
        logic [2:0]  ops [4] = '{3'b100, 3'b110, 3'b100, 3'b110};
        logic [31:0] as  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        int lat;
        for (int k = 0; k < 4; k++) begin
            start(ops[k], as[k], bs[k]);
            wait_valid(lat);
            n_cmp++;
            if (lat !== 1 || result !== exp[k])
                begin n_bad++; $display("FAIL corner_%0d got %h lat %0d want %h lat 1", k, result, lat, exp[k]); end
            do_ack();
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        start(3'b101, 32'd100, 32'd7);
        wait_valid(lat);
        n_cmp++;
        if (lat !== 34 || result !== 32'd14) begin n_bad++; $display("FAIL bp_first got %h lat %0d want 0000000e lat 34", result, lat); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (out_valid !== 1'b1 || ready !== 1'b0 || result !== 32'd14)
                begin n_bad++; $display("FAIL bp_hold_%0d got v%b r%b %h want v1 r0 0000000e", i, out_valid, ready, result); end
        end
        do_ack();
        n_cmp++;
        if (ready !== 1'b1 || out_valid !== 1'b0)
            begin n_bad++; $display("FAIL bp_after_ack got r%b v%b want r1 v0", ready, out_valid); end
        start(3'b101, 32'd1000, 32'd10);
        n_cmp++;
        if (ready !== 1'b0) begin n_bad++; $display("FAIL b2b_accept got ready %b want 0", ready); end
        wait_valid(lat);
        n_cmp++;
        if (lat !== 34 || result !== 32'd100) begin n_bad++; $display("FAIL b2b_divu got %h lat %0d want 00000064 lat 34", result, lat); end
        do_ack();
    endtask

    task automatic test_flush();
        bit seen;
        int lat;
        start(3'b000, 32'd5, 32'd6);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        n_cmp++;
        if (ready !== 1'b1 || out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_idle got r%b v%b want r1 v0", ready, out_valid); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1;
        end
        n_cmp++;
        if (seen) begin n_bad++; $display("FAIL flush_no_result got valid 1 want 0"); end
        flush = 1'b1;
        start(3'b000, 32'd2, 32'd2);
        n_cmp++;
        if (ready !== 1'b0) begin n_bad++; $display("FAIL flush_in_idle_accept got ready %b want 0", ready); end
        @(posedge clk);
        #1;
        flush = 1'b0;
        n_cmp++;
        if (ready !== 1'b1) begin n_bad++; $display("FAIL flush_calc got ready %b want 1", ready); end
        start(3'b000, 32'd9, 32'd9);
        repeat (20) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        n_cmp++;
        if (ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0)
            begin n_bad++; $display("FAIL reset_mid got r%b v%b %h want r1 v0 00000000", ready, out_valid, result); end
        start(3'b000, 32'd3, 32'd4);
        wait_valid(lat);
        n_cmp++;
        if (lat !== 34 || result !== 32'd12) begin n_bad++; $display("FAIL mul_after_reset got %h lat %0d want 0000000c lat 34", result, lat); end
        do_ack();
    endtask

    initial begin
        test_reset();
        test_mul_latency();
        test_mul_high();
        test_div();
        test_corners();
        test_back_to_back();
        test_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
